// File: rtl/key_event.sv
// key_event: turns the debounced key level into PRESS/RELEASE/LONG/REPEAT events.
// Latency: one clk_i cycle from the sampling edge to evt_valid_o.
// Backpressure: single-entry output register; an event arriving while it is full is dropped and flags overrun_o.
module key_event #(
  parameter int LONG_TICKS   = 200,
  parameter int REPEAT_TICKS = 40,
  parameter int CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pressed_i,
  output logic       evt_valid_o,
  output logic [1:0] evt_code_o,
  input  logic       evt_ready_i,
  output logic       held_o,
  output logic       overrun_o
);

  typedef enum logic [1:0] {
    ST_LOCK = 2'd0,
    ST_IDLE = 2'd1,
    ST_HELD = 2'd2,
    ST_RPT  = 2'd3
  } state_t;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             evt_new;
  logic [1:0]       evt_nxt;
  logic             evt_accept;

  assign evt_accept = evt_valid_o & evt_ready_i;
  assign held_o     = (state == ST_HELD) || (state == ST_RPT);

  // Next-state and event generation; the FSM never looks at backpressure.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_new   = 1'b0;
    evt_nxt   = EVT_PRESS;
    case (state)
      ST_LOCK: begin
        if (!pressed_i) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (pressed_i) begin
          evt_new   = 1'b1;
          evt_nxt   = EVT_PRESS;
          state_nxt = ST_HELD;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!pressed_i) begin
          evt_new   = 1'b1;
          evt_nxt   = EVT_RELEASE;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_C) begin
          evt_new   = 1'b1;
          evt_nxt   = EVT_LONG;
          state_nxt = ST_RPT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        if (!pressed_i) begin
          evt_new   = 1'b1;
          evt_nxt   = EVT_RELEASE;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_C) begin
          evt_new   = 1'b1;
          evt_nxt   = EVT_REPEAT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_LOCK;
      cnt         <= '0;
      evt_valid_o <= 1'b0;
      evt_code_o  <= EVT_PRESS;
      overrun_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (evt_new) begin
        // A simultaneous accept frees the slot, giving a bubble-free handoff.
        if (!evt_valid_o || evt_accept) begin
          evt_code_o  <= evt_nxt;
          evt_valid_o <= 1'b1;
        end else begin
          overrun_o   <= 1'b1;
        end
      end else if (evt_accept) begin
        evt_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_TICKS=8, REPEAT_TICKS=3.
module tb_key_event;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pressed_i = 1'b0;
  logic       evt_valid_o;
  logic [1:0] evt_code_o;
  logic       evt_ready_i = 1'b1;
  logic       held_o;
  logic       overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  key_event #(
    .LONG_TICKS  (8),
    .REPEAT_TICKS(3),
    .CNT_W       (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pressed_i  (pressed_i),
    .evt_valid_o(evt_valid_o),
    .evt_code_o (evt_code_o),
    .evt_ready_i(evt_ready_i),
    .held_o     (held_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       p;
    logic       r;
    logic       ev;
    logic [1:0] ec;
    logic       eh;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic p, input logic r, input logic ev,
                     input logic [1:0] ec, input logic eh, input logic eo);
    vec_t v;
    v.rst = rst; v.p = p; v.r = r; v.ev = ev; v.ec = ec; v.eh = eh; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0b, expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic ev, input logic [1:0] ec,
                           input logic eh, input logic eo);
    check({tag, ".valid"},   idx, {1'b0, evt_valid_o}, {1'b0, ev});
    check({tag, ".code"},    idx, evt_code_o, ec);
    check({tag, ".held"},    idx, {1'b0, held_o}, {1'b0, eh});
    check({tag, ".overrun"}, idx, {1'b0, overrun_o}, {1'b0, eo});
  endtask

  initial begin
    // Reset with key held: LOCK swallows the hold, PRESS only after 0 -> 1.
    add(1, 1, 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 2'b00, 0, 0);
    add(0, 0, 1, 0, 2'b00, 0, 0);
    add(0, 0, 1, 0, 2'b00, 0, 0);
    // Short press of 4 cycles.
    add(0, 1, 1, 1, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 2'b00, 1, 0);
    add(0, 0, 1, 1, 2'b01, 0, 0);
    add(0, 0, 1, 0, 2'b01, 0, 0);
    // PRESS stalled, ready rises on the LONG edge: replacement without overrun.
    add(0, 1, 0, 1, 2'b00, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, 2'b00, 1, 0);
    add(0, 1, 1, 1, 2'b10, 1, 0);
    add(0, 1, 1, 0, 2'b10, 1, 0);
    add(0, 0, 1, 1, 2'b01, 0, 0);
    add(0, 0, 1, 0, 2'b01, 0, 0);
    // Stalled PRESS, RELEASE dropped -> sticky overrun; FSM still back in IDLE.
    add(0, 1, 0, 1, 2'b00, 1, 0);
    add(0, 1, 0, 1, 2'b00, 1, 0);
    add(0, 1, 0, 1, 2'b00, 1, 0);
    add(0, 0, 0, 1, 2'b00, 0, 1);
    add(0, 0, 1, 0, 2'b00, 0, 1);
    add(0, 0, 1, 0, 2'b00, 0, 1);
    add(0, 1, 1, 1, 2'b00, 1, 1);
    add(0, 0, 1, 1, 2'b01, 0, 1);
    add(0, 0, 1, 0, 2'b01, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_i       = tbl[i].rst;
      pressed_i   = tbl[i].p;
      evt_ready_i = tbl[i].r;
      tick();
      check_all("vec", i, tbl[i].ev, tbl[i].ec, tbl[i].eh, tbl[i].eo);
    end

    // Reset pulse at hold cycle 6 with the key still down.
    rst_i = 0; evt_ready_i = 1; pressed_i = 1;
    tick();
    check_all("rst_hold.press", 0, 1, 2'b00, 1, 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_all("rst_hold.hold", i, 0, 2'b00, 1, 1);
    end
    rst_i = 1;
    tick();
    check_all("rst_hold.reset", 5, 0, 2'b00, 0, 0);
    rst_i = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all("rst_hold.locked", i, 0, 2'b00, 0, 0);
    end
    pressed_i = 0;
    tick();
    check_all("rst_hold.unlock", 0, 0, 2'b00, 0, 0);
    pressed_i = 1;
    tick();
    check_all("rst_hold.repress", 0, 1, 2'b00, 1, 0);
    pressed_i = 0;
    tick();
    check_all("rst_hold.release", 0, 1, 2'b01, 0, 0);
    tick();
    check_all("rst_hold.idle", 0, 0, 2'b01, 0, 0);

    // 20-cycle hold: PRESS@k, LONG@k+8, REPEAT@k+11/14/17, RELEASE@k+20.
    begin
      logic [1:0] last_code;
      logic       ev;
      last_code = 2'b01;
      for (int j = 0; j <= 21; j++) begin
        pressed_i = (j < 20);
        tick();
        ev = 1'b1;
        case (j)
          0:           last_code = 2'b00;
          8:           last_code = 2'b10;
          11, 14, 17:  last_code = 2'b11;
          20:          last_code = 2'b01;
          default:     ev = 1'b0;
        endcase
        check_all("long_hold", j, ev, last_code, (j < 20), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the debounced, high-active key level produced by the key debouncer and turns it into discrete key events.
- Event codes: PRESS, RELEASE, LONG (hold threshold reached) and REPEAT (auto-repeat while held).
- Each event is delivered through a single-entry valid/ready output register to the downstream controller (menu/counter FSM).
- Runs on the same 5 ms clock as the debouncer. All time constants are counted in clk_i cycles.

Parameters:
- LONG_TICKS, 200, held cycles after PRESS before LONG is emitted (1 s at 5 ms); must be >= 1
- REPEAT_TICKS, 40, cycles between LONG and the first REPEAT, and between successive REPEATs (200 ms); must be >= 1
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS)

Ports:
- clk_i  input  1  5 ms clock; all logic on its rising edge
- rst_i  input  1  synchronous reset, active-high
- pressed_i  input  1  debounced key level, 1 = pressed
- evt_valid_o  output  1  event register holds an unconsumed event
- evt_code_o  output  2  event code: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- evt_ready_i  input  1  downstream accepts the event at this edge when evt_valid_o=1
- held_o  output  1  1 while state is HELD or REPEAT
- overrun_o  output  1  sticky flag: an event was dropped because the register was full

Behaviour:
- Reset (rst_i=1 at an edge):
  - state <= LOCK, cnt <= 0
  - evt_valid_o=0, evt_code_o=00, held_o=0, overrun_o=0
  - Reset has priority over all other activity.
- LOCK: stay in LOCK while pressed_i=1; go to IDLE when pressed_i=0. No events are emitted, so a key held through reset never produces PRESS.
- IDLE: when pressed_i=1, emit PRESS, state <= HELD, cnt <= 1.
- HELD:
  - pressed_i=0: emit RELEASE, state <= IDLE, cnt <= 0.
  - Otherwise, if cnt==LONG_TICKS: emit LONG, state <= REPEAT, cnt <= 1.
  - Otherwise cnt <= cnt+1.
- REPEAT:
  - pressed_i=0: emit RELEASE, state <= IDLE, cnt <= 0.
  - Otherwise, if cnt==REPEAT_TICKS: emit REPEAT, cnt <= 1.
  - Otherwise cnt <= cnt+1.
- Timing: let edge k be the first edge that samples pressed_i=1 in IDLE.
  - PRESS is visible after edge k.
  - LONG is visible after edge k+LONG_TICKS.
  - REPEAT is visible after edges k+LONG_TICKS+n*REPEAT_TICKS, n>=1.
  - RELEASE is visible after the first edge that samples pressed_i=0.
  - Every event has 1 cycle of latency from the sampling edge.
- The counter never wraps: it is reloaded to 1 on reaching its threshold and cleared on RELEASE.
- Output register and handshake:
  - accept = evt_valid_o & evt_ready_i at an edge.
  - New event with (!evt_valid_o | accept): load the code, evt_valid_o <= 1. Simultaneous accept and new event therefore gives a back-to-back handoff with no bubble.
  - New event with evt_valid_o & !evt_ready_i: the new event is dropped, the held code is unchanged, overrun_o <= 1.
  - No new event and accept: evt_valid_o <= 0. evt_code_o keeps its last value.
  - evt_code_o is stable whenever evt_valid_o=1 and not yet accepted.
  - Dropped events do not alter the FSM: state and counter advance regardless of backpressure.
- overrun_o clears only on reset.
- held_o is decoded from the registered state.
- Reset mid-hold: the counter and any pending event are discarded and the FSM enters LOCK. The next PRESS requires pressed_i to be observed 0, then 1.

Test Plan (bench uses LONG_TICKS=8, REPEAT_TICKS=3, evt_ready_i=1 unless stated):
- Reset with pressed_i=1, hold 5 cycles, drop to 0 for 2 cycles, raise -> no event during the hold; PRESS valid exactly 1 cycle after the first high sample.
- Press for 4 cycles, then release -> PRESS, then RELEASE 4 cycles later; held_o=1 for exactly 4 cycles; no LONG.
- Press held 20 cycles from edge k -> PRESS@k, LONG@k+8, REPEAT@k+11, k+14, k+17, then RELEASE@k+20; each evt_valid_o pulse is 1 cycle wide.
- evt_ready_i=0, press 3 cycles, then release -> evt_valid_o stays 1 with code 00; RELEASE dropped; overrun_o=1 and stays 1 after evt_ready_i rises; FSM returns to IDLE.
- evt_ready_i=0 with PRESS pending; assert evt_ready_i on the same edge that generates LONG (held ≥8) -> evt_code_o becomes 10 next cycle with evt_valid_o still 1; overrun_o remains 0.
- rst_i pulsed 1 cycle at hold cycle 6 while pressed_i stays 1 -> outputs return to reset values; no LONG/REPEAT; new PRESS only after a 0->1 on pressed_i.
